// File: rtl/sha1_base_pio_keys.sv
// Avalon-MM input PIO for the SHA1_Base system: synchronises and debounces the
// key/switch inputs, latches edge events and raises a maskable level interrupt.
module sha1_base_pio_keys #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] data_dly_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] edge_evt_s;
  logic [WIDTH-1:0] clr_s;
  logic             wr_en_s;
  logic             unused_wd_s;

  assign wr_en_s     = chipselect & ~write_n;
  assign unused_wd_s = ^writedata;

  // Per-bit debounce: data follows sync only after DEBOUNCE_CYCLES consecutive differing edges.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != data_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          data_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Edge event selection.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_evt_s = data_q & ~data_dly_q;
      1:       edge_evt_s = ~data_q & data_dly_q;
      default: edge_evt_s = data_q ^ data_dly_q;
    endcase
  end

  // Register writes; capture set takes priority over write-1-to-clear.
  always_comb begin
    irqmask_d = irqmask_q;
    clr_s     = '0;
    if (wr_en_s && address == 2'd2) begin
      irqmask_d = writedata[WIDTH-1:0];
    end else begin
      irqmask_d = irqmask_q;
    end
    if (wr_en_s && address == 2'd3) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    edgecap_d = (edgecap_q & ~clr_s) | edge_evt_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      data_q     <= '0;
      data_dly_q <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      data_q     <= data_d;
      data_dly_q <= data_q;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Zero-wait-state read mux, independent of chipselect.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = data_q;
      2'd2:    readdata[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata[WIDTH-1:0] = edgecap_q;
      default: readdata = 32'd0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_sha1_base_pio_keys.sv
// Scoreboard bench for sha1_base_pio_keys (WIDTH=4, DEBOUNCE_CYCLES=4, falling edges).
module tb_sha1_base_pio_keys;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_port = 4'd0;
  logic [31:0] readdata;
  logic        irq;
  logic        rd_stb = 1'b0;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #10 clk = ~clk;

  sha1_base_pio_keys #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // Monitor: pops the expected response whenever a read strobe is presented.
  always @(posedge rd_stb) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL empty_queue: read observed with no expectation");
    end else begin
      e = exp_q.pop_front();
      n_total++;
      if (readdata === e.data) n_pass++;
      else $display("FAIL %s readdata: got %h expected %h", e.name, readdata, e.data);
      n_total++;
      if (irq === e.irq) n_pass++;
      else $display("FAIL %s irq: got %b expected %b", e.name, irq, e.irq);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic i, input string nm);
    exp_t e;
    e.addr = a; e.data = d; e.irq = i; e.name = nm;
    address = a;
    exp_q.push_back(e);
    #1 rd_stb = 1'b1;
    #1 rd_stb = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    step(3);
    reset_n = 1'b1;
    rd(2'd0, 32'h0, 1'b0, "por_data");
    rd(2'd1, 32'h0, 1'b0, "por_rsvd");
    rd(2'd2, 32'h0, 1'b0, "por_mask");
    rd(2'd3, 32'h0, 1'b0, "por_ecap");

    // Input change 0 -> 5: data updates on edge N+5, rising edge not captured
    in_port = 4'h5;
    for (int k = 0; k < 5; k++) begin
      step(1);
      rd(2'd0, 32'h0, 1'b0, "lat_wait");
    end
    step(1);
    rd(2'd0, 32'h5, 1'b0, "lat_data");
    step(2);
    rd(2'd3, 32'h0, 1'b0, "rise_nocap");
    wr(2'd0, 32'hF);
    rd(2'd0, 32'h5, 1'b0, "data_ro");
    wr(2'd1, 32'hF);
    rd(2'd1, 32'h0, 1'b0, "rsvd_ro");

    // Glitch: bit1 high for 3 cycles is rejected; held high it passes
    in_port = 4'h7;
    step(3);
    in_port = 4'h5;
    step(8);
    rd(2'd0, 32'h5, 1'b0, "glitch_data");
    rd(2'd3, 32'h0, 1'b0, "glitch_ecap");
    in_port = 4'h7;
    step(10);
    rd(2'd0, 32'h7, 1'b0, "held_data");
    in_port = 4'hF;
    step(10);
    rd(2'd0, 32'hF, 1'b0, "all_high");

    // Falling edge on bit1 with irqmask=2
    wr(2'd2, 32'h2);
    in_port = 4'hD;
    step(6);
    rd(2'd0, 32'hD, 1'b0, "fall_data");
    rd(2'd3, 32'h0, 1'b0, "fall_ecap_pre");
    step(1);
    rd(2'd3, 32'h2, 1'b1, "fall_ecap");
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, 1'b0, "w1c_clear");

    // Masked capture of bits 0 and 3
    wr(2'd2, 32'h0);
    in_port = 4'h4;
    step(7);
    rd(2'd3, 32'h9, 1'b0, "masked_ecap");
    rd(2'd0, 32'h4, 1'b0, "masked_data");
    wr(2'd2, 32'h8);
    rd(2'd2, 32'h8, 1'b1, "unmask_irq");

    // Set/clear collision on bit0
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h8, 1'b1, "clr_bit0");
    wr(2'd2, 32'h1);
    rd(2'd3, 32'h8, 1'b0, "mask_bit0");
    in_port = 4'h5;
    step(10);
    rd(2'd0, 32'h5, 1'b0, "bit0_high");
    rd(2'd3, 32'h8, 1'b0, "bit0_rise");
    in_port = 4'h4;
    step(6);
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h9, 1'b1, "collision");
    step(2);
    rd(2'd3, 32'h9, 1'b1, "collision_hold");

    // Mid-run reset with irqmask=F and edgecapture=3
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, 1'b0, "clear_all");
    in_port = 4'h7;
    step(10);
    rd(2'd0, 32'h7, 1'b0, "pre_rst_high");
    in_port = 4'h4;
    step(10);
    rd(2'd3, 32'h3, 1'b1, "pre_rst_ecap");
    wr(2'd2, 32'hF);
    rd(2'd2, 32'hF, 1'b1, "pre_rst_mask");
    in_port = 4'h0;
    reset_n = 1'b0;
    rd(2'd3, 32'h0, 1'b0, "rst_immediate");
    rd(2'd2, 32'h0, 1'b0, "rst_mask");
    step(2);
    reset_n = 1'b1;
    rd(2'd0, 32'h0, 1'b0, "post_rst_data");
    rd(2'd1, 32'h0, 1'b0, "post_rst_rsvd");
    rd(2'd2, 32'h0, 1'b0, "post_rst_mask");
    rd(2'd3, 32'h0, 1'b0, "post_rst_ecap");
    step(10);
    rd(2'd3, 32'h0, 1'b0, "no_pending_edge");
    rd(2'd0, 32'h0, 1'b0, "post_rst_idle");

    step(1);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
